// File: rtl/morse.sv
// Morse code keyer: ASCII characters are queued in a small FIFO and sent
// one by one on a single key line, with International Morse timing built
// from a programmable time unit of PRESCALER clock cycles.
module morse #(
  parameter int PRESCALER = 50_000_000,  // clock cycles per Morse time unit
  parameter int DEPTH     = 16           // FIFO entries, power of two
) (
  input  logic       clk,
  input  logic       arst_n,
  input  logic       write_en,
  input  logic [7:0] ascii_in,
  output logic       full,
  output logic       morse_out
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int TW = (PRESCALER > 1) ? $clog2(PRESCALER) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, MARK, EGAP, CGAP, WGAP} state_t;

  // FIFO storage and bookkeeping
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    rd_data_q;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;

  // Transmitter state
  state_t        state_q;
  logic [TW-1:0] tick_q;
  logic [1:0]    unit_q;
  logic [2:0]    len_q;
  logic [4:0]    mask_q;
  logic          morse_out_q;

  logic [7:0]    ch_upper;
  logic [7:0]    code;
  logic [1:0]    units_last;
  logic          tick_last;
  logic          span_end;

  // Character code: {element count, element mask}; mask bit 0 is the first
  // element sent, a 1 bit is a dash.
  function automatic logic [7:0] encode(input logic [7:0] c);
    case (c)
      8'h41: encode = {3'd2, 5'b00010}; // A .-
      8'h42: encode = {3'd4, 5'b00001}; // B -...
      8'h43: encode = {3'd4, 5'b00101}; // C -.-.
      8'h44: encode = {3'd3, 5'b00001}; // D -..
      8'h45: encode = {3'd1, 5'b00000}; // E .
      8'h46: encode = {3'd4, 5'b00100}; // F ..-.
      8'h47: encode = {3'd3, 5'b00011}; // G --.
      8'h48: encode = {3'd4, 5'b00000}; // H ....
      8'h49: encode = {3'd2, 5'b00000}; // I ..
      8'h4A: encode = {3'd4, 5'b01110}; // J .---
      8'h4B: encode = {3'd3, 5'b00101}; // K -.-
      8'h4C: encode = {3'd4, 5'b00010}; // L .-..
      8'h4D: encode = {3'd2, 5'b00011}; // M --
      8'h4E: encode = {3'd2, 5'b00001}; // N -.
      8'h4F: encode = {3'd3, 5'b00111}; // O ---
      8'h50: encode = {3'd4, 5'b00110}; // P .--.
      8'h51: encode = {3'd4, 5'b01011}; // Q --.-
      8'h52: encode = {3'd3, 5'b00010}; // R .-.
      8'h53: encode = {3'd3, 5'b00000}; // S ...
      8'h54: encode = {3'd1, 5'b00001}; // T -
      8'h55: encode = {3'd3, 5'b00100}; // U ..-
      8'h56: encode = {3'd4, 5'b01000}; // V ...-
      8'h57: encode = {3'd3, 5'b00110}; // W .--
      8'h58: encode = {3'd4, 5'b01001}; // X -..-
      8'h59: encode = {3'd4, 5'b01101}; // Y -.--
      8'h5A: encode = {3'd4, 5'b00011}; // Z --..
      8'h30: encode = {3'd5, 5'b11111}; // 0 -----
      8'h31: encode = {3'd5, 5'b11110}; // 1 .----
      8'h32: encode = {3'd5, 5'b11100}; // 2 ..---
      8'h33: encode = {3'd5, 5'b11000}; // 3 ...--
      8'h34: encode = {3'd5, 5'b10000}; // 4 ....-
      8'h35: encode = {3'd5, 5'b00000}; // 5 .....
      8'h36: encode = {3'd5, 5'b00001}; // 6 -....
      8'h37: encode = {3'd5, 5'b00011}; // 7 --...
      8'h38: encode = {3'd5, 5'b00111}; // 8 ---..
      8'h39: encode = {3'd5, 5'b01111}; // 9 ----.
      default: encode = 8'h00;          // unsupported: zero length
    endcase
  endfunction

  // A write while full is dropped even when a pop frees a slot this edge.
  assign push    = write_en && !full;
  assign pop     = (state_q == IDLE) && (count_q != '0);
  assign count_d = count_q + CW'(push) - CW'(pop);
  assign full    = (count_q == CW'(DEPTH));

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // FIFO storage array with registered read, captured on pop for LOAD
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= ascii_in;
    if (pop)  rd_data_q <= mem_q[rd_ptr_q];
  end

  // Fold lowercase onto uppercase and look up the Morse code
  always_comb begin
    ch_upper = rd_data_q;
    if (rd_data_q >= 8'h61 && rd_data_q <= 8'h7A) ch_upper = rd_data_q - 8'h20;
    code = encode(ch_upper);
  end

  // Last time unit index of each timed state
  always_comb begin
    units_last = 2'd0;
    case (state_q)
      MARK:    units_last = mask_q[0] ? 2'd2 : 2'd0;
      EGAP:    units_last = 2'd0;
      CGAP:    units_last = 2'd1;
      WGAP:    units_last = 2'd3;
      default: units_last = 2'd0;
    endcase
  end

  assign tick_last = (tick_q == TW'(PRESCALER - 1));
  assign span_end  = tick_last && (unit_q == units_last);

  // Transmitter FSM; the key line is registered one cycle behind MARK
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= IDLE;
      tick_q      <= '0;
      unit_q      <= '0;
      len_q       <= '0;
      mask_q      <= '0;
      morse_out_q <= 1'b0;
    end else begin
      morse_out_q <= (state_q == MARK);
      case (state_q)
        IDLE: begin
          tick_q <= '0;
          unit_q <= '0;
          if (count_q != '0) state_q <= LOAD;
        end
        LOAD: begin
          tick_q <= '0;
          unit_q <= '0;
          if (code[7:5] != 3'd0) begin
            len_q   <= code[7:5];
            mask_q  <= code[4:0];
            state_q <= MARK;
          end else if (rd_data_q == 8'h20) begin
            state_q <= WGAP;
          end else begin
            state_q <= IDLE;
          end
        end
        MARK, EGAP, CGAP, WGAP: begin
          if (span_end) begin
            tick_q <= '0;
            unit_q <= '0;
            case (state_q)
              MARK: state_q <= EGAP;
              EGAP: begin
                if (len_q > 3'd1) begin
                  len_q   <= len_q - 3'd1;
                  mask_q  <= {1'b0, mask_q[4:1]};
                  state_q <= MARK;
                end else begin
                  state_q <= CGAP;
                end
              end
              default: state_q <= IDLE;
            endcase
          end else if (tick_last) begin
            tick_q <= '0;
            unit_q <= unit_q + 2'd1;
          end else begin
            tick_q <= tick_q + TW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign morse_out = morse_out_q;

endmodule

// File: tb/tb_morse.sv
// Bench for the Morse keyer: builds the expected key-line waveform and FIFO
// full flag from character patterns, and compares them cycle by cycle.
module tb_morse;
  localparam int P = 4;
  localparam int D = 16;

  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic       write_en = 1'b0;
  logic [7:0] ascii_in = 8'h00;
  logic       full;
  logic       morse_out;

  int checks = 0;
  int failures = 0;

  bit            wave[$];      // expected key line, one entry per cycle
  int            pop_edge[$];  // edge index at which each accepted char pops
  byte unsigned  txq[$];       // characters to write

  string letters[26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....",
                         "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--.",
                         "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-",
                         "-.--", "--.."};
  string digits[10]  = '{"-----", ".----", "..---", "...--", "....-",
                         ".....", "-....", "--...", "---..", "----."};

  always #5 clk = ~clk;

  morse #(.PRESCALER(P), .DEPTH(D)) dut (
    .clk(clk),
    .arst_n(arst_n),
    .write_en(write_en),
    .ascii_in(ascii_in),
    .full(full),
    .morse_out(morse_out)
  );

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic string pattern_of(input byte unsigned c);
    byte unsigned u;
    u = c;
    if (u >= 8'h61 && u <= 8'h7A) u = u - 8'h20;
    if (u >= 8'h41 && u <= 8'h5A) return letters[u - 8'h41];
    if (u >= 8'h30 && u <= 8'h39) return digits[u - 8'h30];
    return "";
  endfunction

  // Append one character's share of the waveform: 2 cycles to pop and load,
  // then marks/gaps for a letter or digit, 4U silence for a space.
  task automatic add_char(input byte unsigned c);
    string p;
    pop_edge.push_back(1 + wave.size());
    repeat (2) wave.push_back(1'b0);
    if (c == 8'h20) begin
      repeat (4 * P) wave.push_back(1'b0);
    end else begin
      p = pattern_of(c);
      for (int k = 0; k < p.len(); k++) begin
        repeat (((p.getc(k) == "-") ? 3 : 1) * P) wave.push_back(1'b1);
        if (k < p.len() - 1) repeat (P) wave.push_back(1'b0);
      end
      if (p.len() > 0) repeat (3 * P) wave.push_back(1'b0);
    end
  endtask

  task automatic set_str(input string s);
    txq.delete();
    for (int i = 0; i < s.len(); i++) txq.push_back(s.getc(i));
  endtask

  // Write txq on consecutive edges (dropping what the model says is full),
  // checking key line and full after every edge until the line has settled.
  task automatic run_seq(input string tag);
    int n;
    int acc;
    int occ;
    int pops;
    int idx;
    bit exp_m;
    n = txq.size();
    acc = 0;
    wave.delete();
    pop_edge.delete();
    for (int t = 0; ; t++) begin
      @(negedge clk);
      pops = 0;
      foreach (pop_edge[j]) if (pop_edge[j] <= t - 1) pops++;
      occ = acc - pops;
      if (t >= 1) begin
        idx = t - 2;
        exp_m = (idx >= 0 && idx < wave.size()) ? wave[idx] : 1'b0;
        check_bit($sformatf("%s morse_out t=%0d", tag, t), morse_out, exp_m);
        check_bit($sformatf("%s full t=%0d", tag, t), full, occ == D);
      end
      if (t < n) begin
        write_en = 1'b1;
        ascii_in = txq[t];
        if (occ < D) begin
          acc++;
          add_char(txq[t]);
        end
      end else begin
        write_en = 1'b0;
        ascii_in = 8'h00;
      end
      if (t > n && t - 2 >= wave.size() + 8) break;
    end
    $display("tb_morse: %s done, %0d chars accepted, %0d cycles", tag, acc, wave.size());
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check_bit("reset morse_out", morse_out, 1'b0);
    check_bit("reset full", full, 1'b0);
    @(posedge clk);
    #2 arst_n = 1'b1;

    set_str("E");
    run_seq("E");
    set_str("A");
    run_seq("A");
    set_str("a");
    run_seq("a");
    set_str("E E");
    run_seq("E_space_E");
    txq.delete();
    txq.push_back(8'h00);
    run_seq("nul");
    set_str("XXXXXXXXXXXXXXXXXX");
    run_seq("overflow");
    set_str("CARS");
    run_seq("CARS");
    set_str(" ARE RED");
    run_seq("ARE_RED");

    // Reset in the middle of the dash of "T", with more characters queued
    @(negedge clk);
    write_en = 1'b1; ascii_in = 8'h54;
    @(negedge clk);
    ascii_in = 8'h45;
    @(negedge clk);
    ascii_in = 8'h45;
    @(negedge clk);
    write_en = 1'b0; ascii_in = 8'h00;
    for (int i = 0; i < 50 && morse_out !== 1'b1; i++) @(negedge clk);
    check_bit("rst dash started", morse_out, 1'b1);
    repeat (5) @(negedge clk);
    check_bit("rst still in dash", morse_out, 1'b1);
    arst_n = 1'b0;
    #1;
    check_bit("rst morse_out immediate", morse_out, 1'b0);
    check_bit("rst full immediate", full, 1'b0);
    repeat (3) @(negedge clk);
    check_bit("rst held morse_out", morse_out, 1'b0);
    @(negedge clk);
    arst_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      check_bit($sformatf("post-rst silence t=%0d", i), morse_out, 1'b0);
    end
    // First edge after release carries a write, which must be accepted
    arst_n = 1'b0;
    @(posedge clk);
    #2 arst_n = 1'b1;
    set_str("E");
    run_seq("E_after_release");

    // Randomized character strings
    for (int it = 0; it < 6; it++) begin
      int len;
      int r;
      txq.delete();
      len = $urandom_range(1, D + 3);
      for (int i = 0; i < len; i++) begin
        r = $urandom_range(0, 9);
        case (r)
          0, 1, 2, 3: txq.push_back(8'(8'h41 + $urandom_range(0, 25)));
          4, 5:       txq.push_back(8'(8'h61 + $urandom_range(0, 25)));
          6, 9:       txq.push_back(8'(8'h30 + $urandom_range(0, 9)));
          7:          txq.push_back(8'h20);
          default:    txq.push_back(8'($urandom_range(0, 255)));
        endcase
      end
      run_seq($sformatf("random%0d", it));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
